// File: rtl/lvds_rx_frame_align.sv
// Frame aligner for a 9-channel x6 LVDS deserializer. It issues bit-slip pulses until
// channel 8 carries the alternating PAT_A/PAT_B frame pattern, then forwards the data channels.
module lvds_rx_frame_align #(
  parameter logic [5:0]  PAT_A       = 6'b111100,
  parameter logic [5:0]  PAT_B       = 6'b000000,
  parameter int unsigned ALIGN_PULSE = 2,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned CHECK_WORDS = 8,
  parameter int unsigned ERR_LIMIT   = 4,
  parameter int unsigned MAX_SLIPS   = 12
) (
  input  logic        rx_clk,
  input  logic        reset_n,
  input  logic        rx_locked,
  input  logic [53:0] rx_data,
  output logic        rx_data_align,
  output logic        aligned,
  output logic [47:0] out_data,
  output logic        out_valid,
  output logic        out_first,
  output logic [3:0]  slip_count,
  output logic [7:0]  relock_count,
  output logic        align_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SLIP,
    S_SETTLE,
    S_CHECK,
    S_LOCKED
  } state_t;

  localparam logic [3:0] PULSE_LAST  = 4'(ALIGN_PULSE - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [7:0] CHECK_LAST  = 8'(CHECK_WORDS - 1);
  localparam logic [3:0] ERR_LAST    = 4'(ERR_LIMIT - 1);
  localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

  state_t      state_q;
  logic [3:0]  timer_q;
  logic [7:0]  good_cnt_q;
  logic [3:0]  err_cnt_q;
  logic [3:0]  slip_cnt_q;
  logic [7:0]  relock_cnt_q;
  logic        align_q;
  logic        aligned_q;
  logic        align_err_q;
  logic [5:0]  prev_ch8_q;
  logic [47:0] out_data_q;
  logic        out_valid_q;
  logic        out_first_q;

  logic [5:0]  ch8;
  logic        word_good;
  logic [3:0]  slip_inc;

  assign ch8       = rx_data[53:48];
  // A word is good only if it forms an A/B pair with the word before it.
  assign word_good = ((ch8 == PAT_A) && (prev_ch8_q == PAT_B)) ||
                     ((ch8 == PAT_B) && (prev_ch8_q == PAT_A));
  assign slip_inc  = (slip_cnt_q == 4'hF) ? 4'hF : slip_cnt_q + 4'd1;

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      good_cnt_q   <= '0;
      err_cnt_q    <= '0;
      slip_cnt_q   <= '0;
      relock_cnt_q <= '0;
      align_q      <= 1'b0;
      aligned_q    <= 1'b0;
      align_err_q  <= 1'b0;
    end else if (!rx_locked) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      slip_cnt_q <= '0;
      align_q    <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      unique case (state_q)
        // First check after PLL lock happens without slipping.
        S_IDLE: begin
          state_q <= S_SETTLE;
          timer_q <= '0;
        end
        S_SLIP: begin
          if (timer_q == PULSE_LAST) begin
            align_q <= 1'b0;
            timer_q <= '0;
            state_q <= S_SETTLE;
          end else begin
            timer_q <= timer_q + 4'd1;
          end
        end
        S_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            good_cnt_q <= '0;
            state_q    <= S_CHECK;
          end else begin
            timer_q <= timer_q + 4'd1;
          end
        end
        S_CHECK: begin
          if (word_good) begin
            if (good_cnt_q == CHECK_LAST) begin
              state_q     <= S_LOCKED;
              aligned_q   <= 1'b1;
              slip_cnt_q  <= '0;
              align_err_q <= 1'b0;
              err_cnt_q   <= '0;
            end else begin
              good_cnt_q <= good_cnt_q + 8'd1;
            end
          end else begin
            state_q    <= S_SLIP;
            align_q    <= 1'b1;
            timer_q    <= '0;
            slip_cnt_q <= slip_inc;
            if (slip_inc == SLIP_MAX) align_err_q <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (word_good) begin
            err_cnt_q <= '0;
          end else if (err_cnt_q == ERR_LAST) begin
            // Count restarts from zero and the slip on entry makes it one.
            state_q      <= S_SLIP;
            aligned_q    <= 1'b0;
            align_q      <= 1'b1;
            timer_q      <= '0;
            err_cnt_q    <= '0;
            slip_cnt_q   <= 4'd1;
            relock_cnt_q <= (relock_cnt_q == 8'hFF) ? 8'hFF : relock_cnt_q + 8'd1;
          end else begin
            err_cnt_q <= err_cnt_q + 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers are reset as well so every output reads 0 out of reset.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_ch8_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
    end else begin
      prev_ch8_q  <= ch8;
      out_data_q  <= rx_data[47:0];
      out_valid_q <= (state_q == S_LOCKED);
      out_first_q <= (state_q == S_LOCKED) && (ch8 == PAT_A);
    end
  end

  assign rx_data_align = align_q;
  assign aligned       = aligned_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_first     = out_first_q;
  assign slip_count    = slip_cnt_q;
  assign relock_count  = relock_cnt_q;
  assign align_error   = align_err_q;

endmodule
